// File: rtl/flappy_game_controller.sv
// Flappy Bird game sequencer: flap button conditioning, IDLE/PLAYING/DYING/GAME_OVER
// control of the pipe and bird blocks, per-frame collision latch and BCD score keeping.
module flappy_game_controller #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int DEATH_FRAMES    = 60
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_flap,
    input  logic        frame_tick,
    input  logic        video_on,
    input  logic        bird_pixel,
    input  logic        pipe_pixel,
    input  logic        floor_hit,
    input  logic        pipe_passed,
    output logic [1:0]  state,
    output logic        pipe_enable,
    output logic        pipe_reset,
    output logic        bird_enable,
    output logic        flap_pulse,
    output logic [11:0] score_bcd,
    output logic [11:0] high_score_bcd,
    output logic        game_over
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_DYING     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DF_W = $clog2(DEATH_FRAMES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DF_W-1:0] DF_LAST = DF_W'(DEATH_FRAMES - 1);

    state_t            state_q, state_d;
    logic              sync0_q, sync0_d, sync1_q, sync1_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              acc_q, acc_d, acc_dly_q, acc_dly_d;
    logic              flap_q, flap_d;
    logic              coll_q, coll_d;
    logic [DF_W-1:0]   death_cnt_q, death_cnt_d;
    logic [11:0]       score_q, score_d, high_q, high_d;
    logic              pipe_reset_q, pipe_reset_d;
    logic              hit;

    // Three-digit BCD increment, saturating at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (flap_q) state_d = ST_PLAYING;
            ST_PLAYING:   if (floor_hit || (frame_tick && coll_q)) state_d = ST_DYING;
            ST_DYING:     if (frame_tick && death_cnt_q == DF_LAST) state_d = ST_GAME_OVER;
            ST_GAME_OVER: if (flap_q) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        state       = state_q;
        pipe_enable = (state_q == ST_PLAYING);
        bird_enable = (state_q == ST_PLAYING) || (state_q == ST_DYING);
        game_over   = (state_q == ST_GAME_OVER);
    end

    always_comb begin
        sync0_d   = btn_flap;
        sync1_d   = sync0_q;
        acc_d     = acc_q;
        db_cnt_d  = '0;
        if (sync1_q != acc_q) begin
            if (db_cnt_q == DB_LAST) acc_d    = sync1_q;
            else                     db_cnt_d = db_cnt_q + DB_W'(1);
        end
        acc_dly_d = acc_q;
        flap_d    = acc_q & ~acc_dly_q;

        // A hit on the frame_tick cycle belongs to the frame that starts next.
        hit    = video_on & bird_pixel & pipe_pixel & (state_q == ST_PLAYING);
        coll_d = frame_tick ? hit : (coll_q | hit);

        death_cnt_d = '0;
        if (state_q == ST_DYING) death_cnt_d = frame_tick ? death_cnt_q + DF_W'(1) : death_cnt_q;

        score_d = score_q;
        if (state_q == ST_IDLE && state_d == ST_PLAYING)   score_d = 12'h000;
        else if (state_q == ST_PLAYING && pipe_passed)     score_d = bcd_inc(score_q);

        high_d = high_q;
        if (state_q == ST_DYING && state_d == ST_GAME_OVER && score_q > high_q) high_d = score_q;

        pipe_reset_d = (state_q == ST_GAME_OVER) && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_q      <= 1'b0;
            sync1_q      <= 1'b0;
            db_cnt_q     <= '0;
            acc_q        <= 1'b0;
            acc_dly_q    <= 1'b0;
            flap_q       <= 1'b0;
            coll_q       <= 1'b0;
            death_cnt_q  <= '0;
            score_q      <= 12'h000;
            high_q       <= 12'h000;
            pipe_reset_q <= 1'b0;
        end else begin
            sync0_q      <= sync0_d;
            sync1_q      <= sync1_d;
            db_cnt_q     <= db_cnt_d;
            acc_q        <= acc_d;
            acc_dly_q    <= acc_dly_d;
            flap_q       <= flap_d;
            coll_q       <= coll_d;
            death_cnt_q  <= death_cnt_d;
            score_q      <= score_d;
            high_q       <= high_d;
            pipe_reset_q <= pipe_reset_d;
        end
    end

    assign flap_pulse     = flap_q;
    assign pipe_reset     = pipe_reset_q;
    assign score_bcd      = score_q;
    assign high_score_bcd = high_q;

endmodule

// File: tb/tb_flappy_game_controller.sv
// Scoreboard bench for flappy_game_controller: directed stimulus queues expected
// output values, a negedge monitor pops and compares them against the DUT.
module tb_flappy_game_controller;

    localparam int DEB = 4;
    localparam int DFR = 3;
    localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_DYING = 2'd2, S_GO = 2'd3;

    logic clk, reset_n, btn_flap, frame_tick, video_on, bird_pixel, pipe_pixel, floor_hit, pipe_passed;
    logic [1:0]  state;
    logic        pipe_enable, pipe_reset, bird_enable, flap_pulse, game_over;
    logic [11:0] score_bcd, high_score_bcd;

    flappy_game_controller #(.DEBOUNCE_CYCLES(DEB), .DEATH_FRAMES(DFR)) dut (
        .clk(clk), .reset_n(reset_n), .btn_flap(btn_flap), .frame_tick(frame_tick),
        .video_on(video_on), .bird_pixel(bird_pixel), .pipe_pixel(pipe_pixel),
        .floor_hit(floor_hit), .pipe_passed(pipe_passed), .state(state),
        .pipe_enable(pipe_enable), .pipe_reset(pipe_reset), .bird_enable(bird_enable),
        .flap_pulse(flap_pulse), .score_bcd(score_bcd), .high_score_bcd(high_score_bcd),
        .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {SIG_STATE, SIG_PEN, SIG_PRST, SIG_BEN, SIG_FLAP, SIG_SCORE, SIG_HIGH, SIG_GO} sig_e;
    typedef struct {
        sig_e        sig;
        logic [11:0] val;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [11:0] pick(input sig_e s);
        case (s)
            SIG_STATE: return {10'd0, state};
            SIG_PEN:   return {11'd0, pipe_enable};
            SIG_PRST:  return {11'd0, pipe_reset};
            SIG_BEN:   return {11'd0, bird_enable};
            SIG_FLAP:  return {11'd0, flap_pulse};
            SIG_SCORE: return score_bcd;
            SIG_HIGH:  return high_score_bcd;
            default:   return {11'd0, game_over};
        endcase
    endfunction

    task automatic check(input exp_t e);
        logic [11:0] act;
        act = pick(e.sig);
        vectors++;
        if (act !== e.val) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, expected %h", e.sig.name(), $time, act, e.val);
        end
    endtask

    // Monitor: drains everything queued since the last negedge.
    always @(negedge clk) begin
        while (q.size() > 0) check(q.pop_front());
    end

    task automatic push_exp(input sig_e s, input logic [11:0] v);
        exp_t e;
        e.sig = s;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_reset();
        push_exp(SIG_STATE, 12'(S_IDLE)); push_exp(SIG_PEN, 0); push_exp(SIG_PRST, 0);
        push_exp(SIG_BEN, 0); push_exp(SIG_FLAP, 0); push_exp(SIG_SCORE, 12'h000);
        push_exp(SIG_HIGH, 12'h000); push_exp(SIG_GO, 0);
    endtask

    // Hold the button: pulse expected at edge N+6 (DEB=4), state change at N+7.
    task automatic press(input logic [1:0] st_after, input logic rst_after);
        btn_flap = 1'b1;
        cyc();
        repeat (5) begin cyc(); push_exp(SIG_FLAP, 0); end
        cyc(); push_exp(SIG_FLAP, 1);
        btn_flap = 1'b0;
        cyc(); push_exp(SIG_FLAP, 0); push_exp(SIG_STATE, 12'(st_after)); push_exp(SIG_PRST, 12'(rst_after));
        cyc(); push_exp(SIG_PRST, 0);
        repeat (6) cyc();
    endtask

    task automatic pass(input int n);
        repeat (n) begin
            pipe_passed = 1'b1; cyc();
            pipe_passed = 1'b0; cyc();
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1; cyc();
        frame_tick = 1'b0; cyc();
    endtask

    // Two DYING ticks, then the third must land in GAME_OVER with the given high score.
    task automatic die_out(input logic [11:0] high_exp);
        tick(); tick(); push_exp(SIG_STATE, 12'(S_DYING));
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        push_exp(SIG_STATE, 12'(S_GO)); push_exp(SIG_GO, 1); push_exp(SIG_HIGH, high_exp);
        push_exp(SIG_PEN, 0); push_exp(SIG_BEN, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete, expected finish before 1000000");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; btn_flap = 0; frame_tick = 0; video_on = 0; bird_pixel = 0;
        pipe_pixel = 0; floor_hit = 0; pipe_passed = 0;
        repeat (2) @(posedge clk);
        #1; exp_reset();
        @(posedge clk); #1 reset_n = 1'b1;
        cyc(); exp_reset();

        // Bounce of three cycles must be rejected.
        btn_flap = 1'b1; repeat (3) cyc(); btn_flap = 1'b0;
        repeat (10) begin cyc(); push_exp(SIG_FLAP, 0); end
        push_exp(SIG_STATE, 12'(S_IDLE));

        // Game A: score arithmetic.
        press(S_PLAY, 0);
        push_exp(SIG_PEN, 1); push_exp(SIG_BEN, 1); push_exp(SIG_SCORE, 12'h000); push_exp(SIG_GO, 0);
        pipe_passed = 1'b1; cyc(); pipe_passed = 1'b0; push_exp(SIG_SCORE, 12'h001);
        cyc(); pass(11); push_exp(SIG_SCORE, 12'h012);
        pass(87); push_exp(SIG_SCORE, 12'h099);
        pass(1);  push_exp(SIG_SCORE, 12'h100);
        pass(899); push_exp(SIG_SCORE, 12'h999);
        pass(1);  push_exp(SIG_SCORE, 12'h999);

        // Overlap outside the visible area is not a collision.
        bird_pixel = 1; pipe_pixel = 1; cyc(); bird_pixel = 0; pipe_pixel = 0;
        repeat (3) cyc(); tick(); push_exp(SIG_STATE, 12'(S_PLAY));

        // Asynchronous reset mid-PLAYING.
        cyc(); #2 reset_n = 1'b0; #1 exp_reset();
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) begin cyc(); push_exp(SIG_PRST, 0); push_exp(SIG_STATE, 12'(S_IDLE)); end

        // Game B: floor exit with coincident pipe_passed, score 5.
        press(S_PLAY, 0);
        pass(4);
        pipe_passed = 1; floor_hit = 1; cyc(); pipe_passed = 0; floor_hit = 0;
        push_exp(SIG_STATE, 12'(S_DYING)); push_exp(SIG_SCORE, 12'h005);
        push_exp(SIG_PEN, 0); push_exp(SIG_BEN, 1);
        pass(2); push_exp(SIG_SCORE, 12'h005);
        die_out(12'h005);
        floor_hit = 1; pipe_passed = 1; repeat (2) cyc(); floor_hit = 0; pipe_passed = 0;
        push_exp(SIG_STATE, 12'(S_GO)); push_exp(SIG_SCORE, 12'h005);
        press(S_IDLE, 1);
        push_exp(SIG_SCORE, 12'h005); push_exp(SIG_HIGH, 12'h005); push_exp(SIG_GO, 0);
        press(S_PLAY, 0);
        push_exp(SIG_SCORE, 12'h000); push_exp(SIG_HIGH, 12'h005);

        // Game C: mid-frame collision, score 7 beats high 5.
        pass(7); push_exp(SIG_SCORE, 12'h007);
        video_on = 1; bird_pixel = 1; pipe_pixel = 1; cyc();
        video_on = 0; bird_pixel = 0; pipe_pixel = 0;
        repeat (3) cyc(); push_exp(SIG_STATE, 12'(S_PLAY));
        frame_tick = 1; cyc(); frame_tick = 0; push_exp(SIG_STATE, 12'(S_DYING));
        cyc();
        die_out(12'h007);
        press(S_IDLE, 1);
        push_exp(SIG_SCORE, 12'h007); push_exp(SIG_HIGH, 12'h007);
        press(S_PLAY, 0);
        push_exp(SIG_SCORE, 12'h000); push_exp(SIG_HIGH, 12'h007);

        // Game D: hit on the frame_tick cycle counts for the following frame; 3 < 7 keeps high.
        pass(3);
        video_on = 1; bird_pixel = 1; pipe_pixel = 1; frame_tick = 1; cyc();
        video_on = 0; bird_pixel = 0; pipe_pixel = 0; frame_tick = 0;
        push_exp(SIG_STATE, 12'(S_PLAY));
        cyc(); push_exp(SIG_STATE, 12'(S_PLAY));
        frame_tick = 1; cyc(); frame_tick = 0; push_exp(SIG_STATE, 12'(S_DYING));
        push_exp(SIG_SCORE, 12'h003);
        cyc();
        die_out(12'h007);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
